// File: rtl/systolic_array_ctrl_pkg.sv
// systolic_pkg: shared types and derived-size helpers for the systolic array
// sequencer.
//   state_t      : sequencer states IDLE / COMPUTE / DRAIN / DONE
//   diag_w()     : DIAG_W    = 2S-1, number of PE diagonals
//   row_idx_w()  : ROW_IDX_W = $clog2(S), width of a row index
//   compute_len(): K+2S-2, cycles spent in COMPUTE
//   cnt_w()      : phase counter width, holds K+2S-2 at the largest K
// The sizes are functions because S is a parameter of the modules that use them.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int unsigned diag_w(input int unsigned s);
    return 2 * s - 1;
  endfunction

  function automatic int unsigned row_idx_w(input int unsigned s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  function automatic int unsigned compute_len(input int unsigned k, input int unsigned s);
    return k + 2 * s - 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned kw, input int unsigned s);
    return $clog2(compute_len((32'd1 << kw) - 32'd1, s) + 32'd1);
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// systolic_array_ctrl_if: tile command/status handshake of the sequencer.
//   start  : begin a tile (host -> sequencer)
//   abort  : cancel a running tile (host -> sequencer)
//   k_len  : reduction length K, K_WIDTH bits (host -> sequencer)
//   busy   : tile in progress (sequencer -> host)
//   done   : one-cycle completion pulse (sequencer -> host)
// master = host side, slave = sequencer side.
interface systolic_array_ctrl_if #(
  parameter int unsigned K_WIDTH = 10
);

  logic               start;
  logic               abort;
  logic [K_WIDTH-1:0] k_len;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, k_len,
    input  busy, done
  );

  modport slave (
    input  start, abort, k_len,
    output busy, done
  );

endinterface

// File: rtl/systolic_array_ctrl_wavefront_gen.sv
// systolic_wavefront_gen: registered per-diagonal accumulate mask.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_c        : COMPUTE cycle counter value for the coming cycle
//   i_k        : reduction length K
//   i_en       : coming cycle is a COMPUTE cycle
//   i_drain    : coming cycle is a DRAIN cycle (lower S bits forced high)
//   o_mask     : set_reg_compute, bit d high iff d <= c < d+K
module systolic_wavefront_gen
  import systolic_pkg::*;
#(
  parameter  int unsigned SYSTOLIC_SIZE = 16,
  parameter  int unsigned K_WIDTH       = 10,
  parameter  int unsigned CNT_W         = cnt_w(K_WIDTH, SYSTOLIC_SIZE),
  localparam int unsigned DIAG_W        = diag_w(SYSTOLIC_SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   i_c,
  input  logic [K_WIDTH-1:0] i_k,
  input  logic               i_en,
  input  logic               i_drain,
  output logic [DIAG_W-1:0]  o_mask
);

  logic [DIAG_W-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    if (i_drain) begin
      w_mask[SYSTOLIC_SIZE-1:0] = '1;
    end else if (i_en) begin
      // c - d < K is only evaluated once c >= d, so the subtraction never wraps
      for (int unsigned d = 0; d < DIAG_W; d++) begin
        w_mask[d] = (32'(i_c) >= d) && ((32'(i_c) - d) < 32'(i_k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mask <= '0;
    end else begin
      o_mask <= w_mask;
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: tile sequencer for an S x S PE array.
// One accepted start runs COMPUTE (K+2S-2 cycles, skewed operand feed and
// per-diagonal accumulate windows), DRAIN (S cycles, bottom-row shift-out)
// and a one-cycle DONE.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ctl             : slave side of systolic_array_ctrl_if (start/abort/k_len/busy/done)
//   feed_rd_en      : operand buffer read enable (top and left)
//   set_reg_compute : per-diagonal accumulate enable, bit d = PEs with i+j=d
//   set_reg_write   : per-row shift enable for rows 1..S-1 during drain
//   ofm_write_en    : array in drain mode
//   sel_mux         : PE psum mux, 0 = accumulate, 1 = pass psum_in down
//   ofm_valid       : result bus holds a valid row
//   ofm_row_idx     : array row currently on the result bus
//   tile_cycles     : busy-cycle count of current/last tile (only with
//                     SYSTOLIC_CTRL_PERF_CNT_EN defined)
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter  int unsigned SYSTOLIC_SIZE = 16,
  parameter  int unsigned DATA_WIDTH    = 8,
  parameter  int unsigned K_WIDTH       = 10,
  localparam int unsigned DIAG_W        = diag_w(SYSTOLIC_SIZE),
  localparam int unsigned ROW_IDX_W     = row_idx_w(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  systolic_array_ctrl_if.slave     ctl,
  output logic                     feed_rd_en,
  output logic [DIAG_W-1:0]        set_reg_compute,
  output logic [SYSTOLIC_SIZE-2:0] set_reg_write,
  output logic                     ofm_write_en,
  output logic                     sel_mux,
  output logic                     ofm_valid,
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  output logic [31:0]              tile_cycles,
`endif
  output logic [ROW_IDX_W-1:0]     ofm_row_idx
);

  localparam int unsigned S     = SYSTOLIC_SIZE;
  localparam int unsigned CNT_W = cnt_w(K_WIDTH, S);

  // DATA_WIDTH only documents the psum width (2*DATA_WIDTH) of the array.
  if (DATA_WIDTH == 0 || S < 2) begin : g_cfg_err
    $error("systolic_array_ctrl: unsupported SYSTOLIC_SIZE/DATA_WIDTH");
  end

  state_t             r_state;
  state_t             w_nxt_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [CNT_W-1:0]   w_last_c;
  logic [K_WIDTH-1:0] r_k;
  logic [K_WIDTH-1:0] w_nxt_k;
  logic               w_start_ok;
  logic               w_nxt_drain;
  logic               r_busy;
  logic               r_done;

  assign w_start_ok  = (r_state == IDLE) && ctl.start && (ctl.k_len != '0);
  assign w_last_c    = CNT_W'(compute_len(32'(r_k), S) - 32'd1);
  assign w_nxt_drain = (w_nxt_state == DRAIN);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_k     = r_k;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_nxt_state = COMPUTE;
          w_nxt_cnt   = '0;
          w_nxt_k     = ctl.k_len;
        end
      end
      COMPUTE: begin
        if (ctl.abort) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
        end else if (r_cnt == w_last_c) begin
          w_nxt_state = DRAIN;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (ctl.abort) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
        end else if (r_cnt == CNT_W'(S - 1)) begin
          w_nxt_state = DONE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state/counter so that each output
  // lines up with the cycle the state register describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_k           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      feed_rd_en    <= 1'b0;
      set_reg_write <= '0;
      ofm_write_en  <= 1'b0;
      sel_mux       <= 1'b0;
      ofm_valid     <= 1'b0;
      ofm_row_idx   <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_k           <= w_nxt_k;
      r_busy        <= (w_nxt_state != IDLE);
      r_done        <= (w_nxt_state == DONE);
      feed_rd_en    <= (w_nxt_state == COMPUTE) && (w_nxt_cnt < CNT_W'(w_nxt_k));
      set_reg_write <= w_nxt_drain ? '1 : '0;
      ofm_write_en  <= w_nxt_drain;
      sel_mux       <= w_nxt_drain;
      ofm_valid     <= w_nxt_drain;
      ofm_row_idx   <= w_nxt_drain ? ROW_IDX_W'(S - 1 - 32'(w_nxt_cnt)) : '0;
    end
  end

  assign ctl.busy = r_busy;
  assign ctl.done = r_done;

  systolic_wavefront_gen #(
    .SYSTOLIC_SIZE (S),
    .K_WIDTH       (K_WIDTH),
    .CNT_W         (CNT_W)
  ) u_wavefront (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_c     (w_nxt_cnt),
    .i_k     (w_nxt_k),
    .i_en    (w_nxt_state == COMPUTE),
    .i_drain (w_nxt_drain),
    .o_mask  (set_reg_compute)
  );

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] r_tile_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile_cycles <= '0;
    end else if (w_start_ok) begin
      r_tile_cycles <= '0;
    end else if (r_busy && (r_tile_cycles != '1)) begin
      r_tile_cycles <= r_tile_cycles + 32'd1;
    end
  end

  assign tile_cycles = r_tile_cycles;
`endif

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencer for the SYSTOLIC_SIZE×SYSTOLIC_SIZE PE array. After one `start` it runs a full tile:
- feeds the skewed operand streams;
- opens each PE-diagonal accumulate window for exactly `k_len` cycles;
- drains the accumulated psums out of the bottom row, one row per cycle.

It drives every control input of the array and the read enables of the operand buffers that feed `top_in`/`left_in`.

## Interface
- SYSTOLIC_SIZE, 16, array dimension S
- DATA_WIDTH, 8, operand width (psum width = 2·DATA_WIDTH, passed through only for documentation)
- K_WIDTH, 10, width of the reduction-length field
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- abort  in  1  synchronous cancel of a running tile
- k_len  in  K_WIDTH  reduction length K; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse at tile completion
- feed_rd_en  out  1  read enable for the operand buffers (top and left)
- set_reg_compute  out  2S-1  per-diagonal accumulate enable; bit d covers PEs with i+j=d
- set_reg_write  out  S-1  per-row shift enable for rows 1..S-1 during drain
- ofm_write_en  out  1  array in write-out (drain) mode
- sel_mux  out  1  PE psum mux: 0 = accumulate, 1 = pass psum_in down
- ofm_valid  out  1  `result` bus holds a valid row this cycle
- ofm_row_idx  out  $clog2(S)  array row index currently on `result`

## Operation
- States: IDLE → COMPUTE → DRAIN → DONE → IDLE.
- IDLE: all outputs 0.
  - start=1 with k_len≠0 latches K and enters COMPUTE next cycle.
  - start=1 with k_len=0 is ignored: no state change, no done.
- COMPUTE lasts K+2S−2 cycles, counter c = 0..K+2S−3.
  - feed_rd_en=1 for c<K.
  - set_reg_compute[d]=1 iff d ≤ c < d+K (diagonal window follows the operand skew).
  - sel_mux=0, ofm_write_en=0.
- DRAIN lasts S cycles, counter r = 0..S−1.
  - ofm_write_en=1, sel_mux=1.
  - set_reg_write all ones; set_reg_compute[S−1:0] all ones, upper bits 0.
  - ofm_valid=1, ofm_row_idx=S−1−r.
- DONE: one cycle; done=1, busy=1; all array controls 0; return to IDLE.
- start while not IDLE: ignored; K is not re-latched.
- abort=1 in COMPUTE/DRAIN/DONE: next cycle IDLE with all outputs 0, no done pulse.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: start wins.
- All outputs are registered; counters are sized to hold K+2S−2 without wrap at K = 2^K_WIDTH−1.

## Timing
- Reset: state IDLE, counters 0, every output 0.
- Accepted start in cycle 0:
  - first COMPUTE cycle is cycle 1;
  - feed_rd_en is high in cycles 1..K;
  - set_reg_compute[d] is high in cycles 1+d..K+d.
- DRAIN occupies cycles K+2S−1 .. K+3S−2.
- done pulse in cycle K+3S−1; busy falls in cycle K+3S; next start is accepted in cycle K+3S.
- Tile latency from start to done is K+3S−1 cycles.

## Configuration
- SYSTOLIC_CTRL_PERF_CNT_EN
  - Defined: adds output `tile_cycles` [31:0], which counts busy cycles of the current or most recent tile. It clears on accepted start, holds after done/abort, saturates at all-ones, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package systolic_pkg:
  - state enum (IDLE, COMPUTE, DRAIN, DONE);
  - the derived constants DIAG_W=2S−1 and ROW_IDX_W=$clog2(S);
  - the compute-length function K+2S−2.
- One sub-module, systolic_wavefront_gen: takes c, K and an enable, and produces the registered set_reg_compute diagonal mask (the d ≤ c < d+K compare per bit).

## Test plan
- S=4, K=3, start: feed_rd_en cycles 1–3; set_reg_compute[0] high cycles 1–3 and [6] high cycles 7–9; DRAIN cycles 10–13 with ofm_row_idx 3,2,1,0; done at cycle 14 only.
- S=4, K=1: every diagonal bit is high for exactly one cycle, in cycles 1..7; done at cycle 12.
- start with k_len=0, then start held high in COMPUTE with a different k_len: no state change in the first case; in the second, the original K timing is unchanged.
- Abort at COMPUTE c=2 and separately at DRAIN r=1: all outputs are 0 the next cycle, no done, and a new start is accepted the cycle after.
- rst_n asserted mid-DRAIN: outputs 0 asynchronously and the FSM is in IDLE; after release, a fresh K=3 tile matches the first scenario exactly.
- With SYSTOLIC_CTRL_PERF_CNT_EN, S=4, K=3: tile_cycles reads 14 after done and holds; the next start clears it to 0.
